// File: rtl/dlx_pkg.sv
// dlx_pkg: shared DLX constants for the MEM stage.
//   OP_*      : 6-bit opcodes found in instruction bits [31:26]
//   NOP_INST  : the all-zero instruction, used as a pipeline bubble
//   state_e   : MEM-stage control state (idle / waiting for memory)
//   is_mem_opcode() : true for the opcodes that access data memory
package dlx_pkg;

  localparam logic [5:0]  OP_LW    = 6'b000101;
  localparam logic [5:0]  OP_SW    = 6'b001010;
  localparam logic [5:0]  OP_ADDI  = 6'b001000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  function automatic logic is_mem_opcode(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory request/acknowledge port of the MEM stage.
//   dmem_req   : request, held until ack or abort (stage -> memory)
//   dmem_we    : 1 = write, 0 = read               (stage -> memory)
//   dmem_addr  : byte address, ADDR_W bits         (stage -> memory)
//   dmem_wdata : store data                        (stage -> memory)
//   dmem_rdata : load data, valid with dmem_ack    (memory -> stage)
//   dmem_ack   : one-cycle completion strobe       (memory -> stage)
// modport master is the MEM stage, modport slave the data memory.
interface mem_access_stage_if #(
  parameter int ADDR_W = 16
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: cycle counter bounding how long a memory request may wait.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low reset
//   clear_i : force the count to zero (has priority over en_i)
//   en_i    : count up by one
//   tc_o    : terminal count, high while the count equals TIMEOUT-1
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: DLX MEM stage.
// Takes the EX/MEM latch, performs LW/SW over a variable-latency req/ack
// data-memory port (stalling execute while busy) and presents registered
// MEM/WB outputs to writeback. Non-memory instructions pass in one cycle.
//   clock4, reset4        : clock (rising edge), synchronous active-low reset
//   alu_in4, bin4         : ALU result / effective address, store data
//   inst_in4, mem_en_in4  : instruction (opcode [31:26]), memory-op flag
//   stall4                : combinational hold request to execute
//   dmem                  : data-memory port (master side)
//   alu_out4, lmd_out4    : ALU result and loaded data to writeback
//   inst_out4             : instruction to writeback, 0 = bubble
//   mem_err4              : one-cycle pulse on bad address or timeout
module mem_access_stage
  import dlx_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int TIMEOUT  = 64,
  parameter int ALIGN_CK = 1
) (
  input  logic                      clock4,
  input  logic                      reset4,
  input  logic [31:0]               alu_in4,
  input  logic [31:0]               bin4,
  input  logic [31:0]               inst_in4,
  input  logic                      mem_en_in4,
  output logic                      stall4,
  mem_access_stage_if.master        dmem,
  output logic [31:0]               alu_out4,
  output logic [31:0]               lmd_out4,
  output logic [31:0]               inst_out4,
  output logic                      mem_err4
);

  state_e            state_q;
  logic              dmem_req_q;
  logic              dmem_we_q;
  logic [ADDR_W-1:0] dmem_addr_q;
  logic [31:0]       dmem_wdata_q;
  logic [31:0]       alu_out_q;
  logic [31:0]       lmd_out_q;
  logic [31:0]       inst_out_q;
  logic              mem_err_q;

  logic mem_op_s;
  logic is_sw_s;
  logic bad_s;
  logic tc_s;

  assign mem_op_s = mem_en_in4 & is_mem_opcode(inst_in4[31:26]);
  assign is_sw_s  = (inst_in4[31:26] == OP_SW);
  // Addresses with bit 31 set are outside data memory; misalignment only when enabled.
  assign bad_s    = alu_in4[31] | ((ALIGN_CK != 0) & (|alu_in4[1:0]));

  // Counter is zeroed while idle, so the first WAIT cycle sees count 0.
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk_i   (clock4),
    .rst_ni  (reset4),
    .clear_i (state_q == S_IDLE),
    .en_i    (state_q == S_WAIT),
    .tc_o    (tc_s)
  );

  // stall: hold execute while a good request is launched or still outstanding
  always_comb begin
    stall4 = 1'b0;
    case (state_q)
      S_IDLE:  stall4 = mem_op_s & ~bad_s;
      S_WAIT:  stall4 = ~dmem.dmem_ack & ~tc_s;
      default: stall4 = 1'b0;
    endcase
  end

  // control FSM plus all registered MEM/WB and memory-port outputs
  always_ff @(posedge clock4) begin
    if (!reset4) begin
      state_q      <= S_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= 32'h0000_0000;
      alu_out_q    <= 32'h0000_0000;
      lmd_out_q    <= 32'h0000_0000;
      inst_out_q   <= NOP_INST;
      mem_err_q    <= 1'b0;
    end else begin
      mem_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          alu_out_q <= alu_in4;
          lmd_out_q <= 32'h0000_0000;
          if (!mem_op_s) begin
            inst_out_q <= inst_in4;
          end else if (bad_s) begin
            inst_out_q <= NOP_INST;
            mem_err_q  <= 1'b1;
          end else begin
            state_q      <= S_WAIT;
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= is_sw_s;
            dmem_addr_q  <= alu_in4[ADDR_W-1:0];
            dmem_wdata_q <= bin4;
            inst_out_q   <= NOP_INST;
          end
        end
        S_WAIT: begin
          // inputs are held by stall4, so the instruction is still on inst_in4
          if (dmem.dmem_ack) begin
            state_q    <= S_IDLE;
            dmem_req_q <= 1'b0;
            alu_out_q  <= alu_in4;
            inst_out_q <= inst_in4;
            lmd_out_q  <= dmem_we_q ? 32'h0000_0000 : dmem.dmem_rdata;
          end else if (tc_s) begin
            state_q    <= S_IDLE;
            dmem_req_q <= 1'b0;
            mem_err_q  <= 1'b1;
            inst_out_q <= NOP_INST;
            lmd_out_q  <= 32'h0000_0000;
          end else begin
            state_q <= S_WAIT;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          dmem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign dmem.dmem_req   = dmem_req_q;
  assign dmem.dmem_we    = dmem_we_q;
  assign dmem.dmem_addr  = dmem_addr_q;
  assign dmem.dmem_wdata = dmem_wdata_q;
  assign alu_out4        = alu_out_q;
  assign lmd_out4        = lmd_out_q;
  assign inst_out4       = inst_out_q;
  assign mem_err4        = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (TIMEOUT=8, ALIGN_CK=1, ADDR_W=16).
// Single-cycle cases come from a vector table; multi-cycle cases are hand
// sequences; random instructions are checked against a transaction-level model.
module tb_mem_access_stage;
  import dlx_pkg::*;

  localparam int TO = 8;

  logic        clock4 = 1'b0;
  logic        reset4;
  logic [31:0] alu_in4, bin4, inst_in4;
  logic        mem_en_in4;
  logic        stall4;
  logic [31:0] alu_out4, lmd_out4, inst_out4;
  logic        mem_err4;

  mem_access_stage_if #(.ADDR_W(16)) dif ();

  mem_access_stage #(.ADDR_W(16), .TIMEOUT(TO), .ALIGN_CK(1)) dut (
    .clock4     (clock4),
    .reset4     (reset4),
    .alu_in4    (alu_in4),
    .bin4       (bin4),
    .inst_in4   (inst_in4),
    .mem_en_in4 (mem_en_in4),
    .stall4     (stall4),
    .dmem       (dif),
    .alu_out4   (alu_out4),
    .lmd_out4   (lmd_out4),
    .inst_out4  (inst_out4),
    .mem_err4   (mem_err4)
  );

  always #5 clock4 = ~clock4;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock4);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] rest);
    return {op, rest};
  endfunction

  // Transaction-level expectation for one instruction whose memory ack
  // (if any) arrives L cycles after the request rises.
  typedef struct {
    int          busy;   // cycles with stall4=1, equals cycles with dmem_req=1
    logic        err;
    logic [31:0] inst;
    logic [31:0] lmd;
  } exp_t;

  function automatic exp_t model(input logic [31:0] alu, input logic [31:0] inst,
                                 input logic en, input int lat, input logic [31:0] rdata);
    exp_t e;
    logic [5:0] op = inst[31:26];
    bit memop = en && (op == OP_LW || op == OP_SW);
    bit bad   = alu[31] || ((alu % 4) != 0);
    e.busy = 0; e.err = 1'b0; e.inst = inst; e.lmd = 32'h0;
    if (memop && bad) begin
      e.err = 1'b1; e.inst = 32'h0;
    end else if (memop && lat < TO) begin
      e.busy = lat + 1;
      e.lmd  = (op == OP_LW) ? rdata : 32'h0;
    end else if (memop) begin
      e.busy = TO; e.err = 1'b1; e.inst = 32'h0;
    end
    return e;
  endfunction

  // Present one instruction, act as the memory, and check the outcome.
  task automatic run(input string tag, input logic [31:0] alu, input logic [31:0] bin,
                     input logic [31:0] inst, input logic en, input int lat,
                     input logic [31:0] rdata);
    exp_t e;
    int st = 0, rq = 0, w = 0;
    bit done = 0;
    e = model(alu, inst, en, lat, rdata);
    alu_in4 = alu; bin4 = bin; inst_in4 = inst; mem_en_in4 = en;
    for (int c = 0; c < TO + 4 && !done; c++) begin
      if (dif.dmem_req) begin
        rq++;
        if (w == 0) begin
          chk({tag, " addr"},  {16'h0, dif.dmem_addr}, {16'h0, alu[15:0]});
          chk({tag, " we"},    {31'h0, dif.dmem_we}, {31'h0, inst[31:26] == OP_SW});
          chk({tag, " wdata"}, dif.dmem_wdata, bin);
        end
        dif.dmem_ack   = (w == lat);
        dif.dmem_rdata = (w == lat) ? rdata : $urandom;
        w++;
      end else begin
        dif.dmem_ack = 1'b0;
      end
      #1;
      if (stall4) st++;
      else done = 1;
      tick();
    end
    dif.dmem_ack = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL %s stall_bound: stall4 still high after %0d cycles", tag, TO + 4);
    end
    chk({tag, " stall_cycles"}, st, e.busy);
    chk({tag, " req_cycles"},   rq, e.busy);
    chk({tag, " inst_out"},     inst_out4, e.inst);
    chk({tag, " lmd_out"},      lmd_out4, e.lmd);
    chk({tag, " mem_err"},      {31'h0, mem_err4}, {31'h0, e.err});
    chk({tag, " req_after"},    {31'h0, dif.dmem_req}, 32'h0);
    if (e.inst != 32'h0) chk({tag, " alu_out"}, alu_out4, alu);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " req"},  {31'h0, dif.dmem_req}, 32'h0);
    chk({tag, " alu"},  alu_out4, 32'h0);
    chk({tag, " lmd"},  lmd_out4, 32'h0);
    chk({tag, " inst"}, inst_out4, 32'h0);
    chk({tag, " err"},  {31'h0, mem_err4}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] alu, bin, inst;
    logic        en;
    logic        stall, err;
    logic [31:0] inst_o;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addi_i;
    addi_i = mk(OP_ADDI, 26'h0000015);
    tbl[0] = '{32'h15,       32'h0, addi_i,                    1'b0, 1'b0, 1'b0, addi_i};
    tbl[1] = '{32'h42,       32'h0, mk(OP_LW, 26'h0000042),    1'b1, 1'b0, 1'b1, 32'h0};
    tbl[2] = '{32'h80000000, 32'h9, mk(OP_SW, 26'h0000001),    1'b1, 1'b0, 1'b1, 32'h0};
    tbl[3] = '{32'h7,        32'h0, mk(OP_ADDI, 26'h0000007),  1'b1, 1'b0, 1'b0, mk(OP_ADDI, 26'h0000007)};
    tbl[4] = '{32'h40,       32'h0, mk(OP_LW, 26'h0000040),    1'b0, 1'b0, 1'b0, mk(OP_LW, 26'h0000040)};
    tbl[5] = '{32'h80000004, 32'h5, mk(OP_SW, 26'h0000004),    1'b1, 1'b0, 1'b1, 32'h0};

    reset4 = 1'b0; alu_in4 = 32'h0; bin4 = 32'h0; inst_in4 = 32'h0; mem_en_in4 = 1'b0;
    dif.dmem_ack = 1'b0; dif.dmem_rdata = 32'h0;
    tick(); tick();
    chk_zero("por");
    reset4 = 1'b1;
    tick();

    // single-cycle vector table: passthrough and bad-address cases
    for (int i = 0; i < 6; i++) begin
      alu_in4 = tbl[i].alu; bin4 = tbl[i].bin; inst_in4 = tbl[i].inst; mem_en_in4 = tbl[i].en;
      #1;
      chk($sformatf("tbl%0d stall", i), {31'h0, stall4}, {31'h0, tbl[i].stall});
      tick();
      chk($sformatf("tbl%0d inst_out", i), inst_out4, tbl[i].inst_o);
      chk($sformatf("tbl%0d err", i), {31'h0, mem_err4}, {31'h0, tbl[i].err});
      chk($sformatf("tbl%0d lmd", i), lmd_out4, 32'h0);
      chk($sformatf("tbl%0d req", i), {31'h0, dif.dmem_req}, 32'h0);
      if (tbl[i].inst_o != 32'h0) chk($sformatf("tbl%0d alu", i), alu_out4, tbl[i].alu);
    end

    // LW with ack three cycles after request, SW with immediate ack
    run("lw_ack3", 32'h40, 32'h0, mk(OP_LW, 26'h0000040), 1'b1, 3, 32'hDEADBEEF);
    run("sw_ack0", 32'h44, 32'h1234, mk(OP_SW, 26'h0000044), 1'b1, 0, 32'hFFFF0000);
    // back-to-back loads
    run("lw_b2b0", 32'h100, 32'h0, mk(OP_LW, 26'h0000100), 1'b1, 1, 32'h11112222);
    run("lw_b2b1", 32'h104, 32'h0, mk(OP_LW, 26'h0000104), 1'b1, 0, 32'h33334444);
    // ack on the last allowed cycle still completes
    run("lw_ack7", 32'h48, 32'h0, mk(OP_LW, 26'h0000048), 1'b1, TO - 1, 32'h0BADF00D);
    // no ack at all: timeout
    run("lw_tmo", 32'h4C, 32'h0, mk(OP_LW, 26'h000004C), 1'b1, 1000, 32'h0);

    // late ack arriving while idle is ignored
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hCAFECAFE;
    alu_in4 = 32'h21; inst_in4 = mk(OP_ADDI, 26'h0000021); mem_en_in4 = 1'b0;
    #1;
    chk("late_ack stall", {31'h0, stall4}, 32'h0);
    tick();
    dif.dmem_ack = 1'b0;
    chk("late_ack inst", inst_out4, mk(OP_ADDI, 26'h0000021));
    chk("late_ack lmd", lmd_out4, 32'h0);
    chk("late_ack err", {31'h0, mem_err4}, 32'h0);
    chk("late_ack req", {31'h0, dif.dmem_req}, 32'h0);

    // reset held for two edges in the middle of a wait
    alu_in4 = 32'h50; inst_in4 = mk(OP_LW, 26'h0000050); mem_en_in4 = 1'b1;
    tick(); tick();
    chk("rst_pre req", {31'h0, dif.dmem_req}, 32'h1);
    reset4 = 1'b0;
    tick();
    chk_zero("rst_e1");
    tick();
    chk_zero("rst_e2");
    mem_en_in4 = 1'b0;
    reset4 = 1'b1;
    run("post_rst", 32'h33, 32'h0, mk(OP_ADDI, 26'h0000033), 1'b0, 0, 32'h0);

    // randomized instructions against the model
    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 3);
      logic [31:0] a = {($urandom_range(0, 7) == 0), 15'h0, 16'($urandom)};
      logic [5:0] op = (kind == 0) ? OP_ADDI : (kind == 1) ? OP_LW : OP_SW;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      run($sformatf("rnd%0d", n), a, $urandom, mk(op, 26'($urandom)),
          1'($urandom_range(0, 5) != 0), $urandom_range(0, 10), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
